// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
//   Multiplexed N-digit seven-segment driver. The divider's segment-rate square
//   wave is edge-detected in the clk_in domain and used as a scan strobe, so
//   everything runs on clk_in. Display data is double-buffered: a load lands in
//   a shadow register and is promoted to the active register only on a frame
//   wrap (digit N-1 -> 0), so a frame never shows a mix of old and new digits.
//
// Optional feature: define SEG7_BLINK_EN to add blink_in / blink_mask. While
//   blink_in=1, a selected digit whose mask bit is set has its enable forced off.
//
// Ports
//   clk_in      system clock
//   reset       async active-low reset
//   scan_in     scan strobe level (sync to clk_in); one advance per rising edge
//   data_in     hex nibbles, nibble i -> digit i
//   dp_in       decimal point per digit, 1 = lit
//   load        capture data_in/dp_in into the shadow
//   blink_in    (SEG7_BLINK_EN) blink phase
//   blink_mask  (SEG7_BLINK_EN) digits that blink
//   load_ack    one-cycle pulse when new data reaches the active register
//   pending     shadow holds data not yet displayed
//   digit_idx   currently selected digit
//   an_out      one-hot digit enable (polarity per AN_ACTIVE_LOW)
//   seg_out     segments, bit0=a .. bit6=g (polarity per SEG_ACTIVE_LOW)
//   dp_out      decimal point of the selected digit (polarity per SEG_ACTIVE_LOW)
module seg7_scan_mux #(
  parameter int N_DIGITS       = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  scan_in,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
`ifdef SEG7_BLINK_EN
  input  logic                  blink_in,
  input  logic [N_DIGITS-1:0]   blink_mask,
`endif
  output logic                  load_ack,
  output logic                  pending,
  output logic [2:0]            digit_idx,
  output logic [N_DIGITS-1:0]   an_out,
  output logic [6:0]            seg_out,
  output logic                  dp_out
);

  localparam logic [2:0]          LAST    = 3'(N_DIGITS - 1);
  localparam logic                SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic                AN_INV  = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]          SEG_OFF = {7{SEG_INV}};
  localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{AN_INV}};

  // active-high segment patterns, g..a
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  logic                  scan_q, running_q, running_d;
  logic [2:0]            digit_q, digit_d;
  logic [4*N_DIGITS-1:0] act_data_q, act_data_d, sh_data_q, sh_data_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic                  pend_q, pend_d, ack_q, ack_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  tick, wrap;

  assign tick = scan_in & ~scan_q;
  assign wrap = tick & (digit_q == LAST);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      scan_q     <= 1'b0;
      running_q  <= 1'b0;
      digit_q    <= LAST;
      act_data_q <= '0;
      act_dp_q   <= '0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
      dp_q       <= SEG_INV;
    end else begin
      scan_q     <= scan_in;
      running_q  <= running_d;
      digit_q    <= digit_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  // scan position and double-buffer control
  always_comb begin
    running_d  = running_q | tick;
    digit_d    = digit_q;
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    pend_d     = pend_q;
    ack_d      = wrap & (load | pend_q);
    if (tick) digit_d = wrap ? 3'd0 : digit_q + 3'd1;
    if (wrap && load) begin
      // load coinciding with the wrap bypasses the shadow; stale shadow is dropped
      act_data_d = data_in;
      act_dp_d   = dp_in;
      pend_d     = 1'b0;
    end else if (wrap && pend_q) begin
      act_data_d = sh_data_q;
      act_dp_d   = sh_dp_q;
      pend_d     = 1'b0;
    end else if (load) begin
      sh_data_d = data_in;
      sh_dp_d   = dp_in;
      pend_d    = 1'b1;
    end
  end

  // display decode from current state; registered, so it trails digit_idx by one clock
  always_comb begin
    logic [3:0]          nib;
    logic                dp_sel;
    logic [N_DIGITS-1:0] hot;
    nib    = '0;
    dp_sel = 1'b0;
    hot    = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digit_q == 3'(i)) begin
        nib    = act_data_q[4*i +: 4];
        dp_sel = act_dp_q[i];
        hot[i] = 1'b1;
`ifdef SEG7_BLINK_EN
        if (blink_in && blink_mask[i]) hot[i] = 1'b0;
`endif
      end
    end
    if (running_q) begin
      an_d  = hot ^ AN_OFF;
      seg_d = hex7(nib) ^ SEG_OFF;
      dp_d  = dp_sel ^ SEG_INV;
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = SEG_INV;
    end
  end

  assign load_ack  = ack_q;
  assign pending   = pend_q;
  assign digit_idx = digit_q;
  assign an_out    = an_q;
  assign seg_out   = seg_q;
  assign dp_out    = dp_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux (N=4, active-low segments and anodes).
// A frame-level reference model runs beside every clock; a hand-derived vector
// table covers the first frame, and short directed sequences cover multi-load,
// load-at-wrap, held strobe, mid-frame reset and (when enabled) blinking.
module tb_seg7_scan_mux;
  localparam int N = 4;

  logic        clk_in = 1'b0, reset = 1'b0, scan_in = 1'b0, load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        blink_in = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic        load_ack, pending, dp_out;
  logic [2:0]  digit_idx;
  logic [3:0]  an_out;
  logic [6:0]  seg_out;

  seg7_scan_mux #(.N_DIGITS(N), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
    .clk_in(clk_in), .reset(reset), .scan_in(scan_in), .data_in(data_in),
    .dp_in(dp_in), .load(load),
`ifdef SEG7_BLINK_EN
    .blink_in(blink_in), .blink_mask(blink_mask),
`endif
    .load_ack(load_ack), .pending(pending), .digit_idx(digit_idx),
    .an_out(an_out), .seg_out(seg_out), .dp_out(dp_out));

  always #5 clk_in = ~clk_in;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] SEG_HI [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int         m_idx;
  bit         m_prev, m_run, m_pend, m_ack;
  logic [3:0] m_act [N];
  logic [3:0] m_sh  [N];
  bit         m_actdp [N];
  bit         m_shdp  [N];
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp;

  task automatic m_reset();
    m_idx = N - 1; m_prev = 0; m_run = 0; m_pend = 0; m_ack = 0;
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_sh[i] = 0; m_actdp[i] = 0; m_shdp[i] = 0;
    end
    m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
  endtask

  // Advance the model across one clock edge given the inputs applied before it.
  task automatic m_step(input bit s, input bit l, input logic [15:0] d, input logic [3:0] p);
    bit tick, wrap, blank;
    // what the display shows after the edge reflects the state before it
    if (m_run) begin
      blank = 0;
`ifdef SEG7_BLINK_EN
      blank = blink_in && blink_mask[m_idx];
`endif
      m_an  = blank ? 4'hF : 4'(~(1 << m_idx));
      m_seg = ~SEG_HI[m_act[m_idx]];
      m_dp  = !m_actdp[m_idx];
    end else begin
      m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
    end
    tick   = s && !m_prev;
    m_prev = s;
    wrap   = tick && (m_idx == N - 1);
    m_ack  = wrap && (l || m_pend);
    if (tick) begin
      m_run = 1;
      m_idx = (m_idx + 1) % N;
    end
    if (wrap && (l || m_pend)) begin
      for (int i = 0; i < N; i++) begin
        m_act[i]   = l ? d[4*i +: 4] : m_sh[i];
        m_actdp[i] = l ? p[i] : m_shdp[i];
      end
      m_pend = 0;
    end else if (l) begin
      for (int i = 0; i < N; i++) begin
        m_sh[i] = d[4*i +: 4]; m_shdp[i] = p[i];
      end
      m_pend = 1;
    end
  endtask

  task automatic cmp_model();
    chk("model ack", 32'(load_ack), 32'(m_ack));
    chk("model pending", 32'(pending), 32'(m_pend));
    chk("model idx", 32'(digit_idx), 32'(m_idx));
    chk("model an", 32'(an_out), 32'(m_an));
    chk("model seg", 32'(seg_out), 32'(m_seg));
    chk("model dp", 32'(dp_out), 32'(m_dp));
  endtask

  // one clock: drive inputs (we sit 1ns after a rising edge), clock, compare
  task automatic cyc(input bit s, input bit l, input logic [15:0] d, input logic [3:0] p);
    scan_in = s; load = l; data_in = d; dp_in = p;
    m_step(s, l, d, p);
    @(posedge clk_in); #1;
    cmp_model();
  endtask

  task automatic chk_blank(input string nm);
    chk({nm, " an"}, 32'(an_out), 32'hF);
    chk({nm, " seg"}, 32'(seg_out), 32'h7F);
    chk({nm, " dp"}, 32'(dp_out), 32'h1);
    chk({nm, " pending"}, 32'(pending), 32'h0);
    chk({nm, " ack"}, 32'(load_ack), 32'h0);
    chk({nm, " idx"}, 32'(digit_idx), 32'h3);
  endtask

  typedef struct {
    bit s; bit l; logic [15:0] d; logic [3:0] p;
    logic [2:0] idx; bit ack; bit pend; logic [3:0] an; logic [6:0] seg; bit dp;
  } vec_t;
  vec_t tbl [11];

  initial begin
    int acks, hits;
    logic [2:0] idx0;
    // first frame after reset: load 8A30 / dp 0010 then four strobes
    tbl[0]  = '{1'b0, 1'b1, 16'h8A30, 4'b0010, 3'd3, 1'b0, 1'b1, 4'hF, 7'h7F, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 4'b0000, 3'd3, 1'b0, 1'b1, 4'hF, 7'h7F, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 3'd0, 1'b1, 1'b0, 4'hF, 7'h7F, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0, 4'hE, 7'h40, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0, 4'hE, 7'h40, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 3'd1, 1'b0, 1'b0, 4'hE, 7'h40, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 4'b0000, 3'd1, 1'b0, 1'b0, 4'hD, 7'h30, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 3'd2, 1'b0, 1'b0, 4'hD, 7'h30, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 4'b0000, 3'd2, 1'b0, 1'b0, 4'hB, 7'h08, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 3'd3, 1'b0, 1'b0, 4'hB, 7'h08, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 4'b0000, 3'd3, 1'b0, 1'b0, 4'h7, 7'h00, 1'b1};

    m_reset();
    #12;
    chk_blank("reset");
    @(posedge clk_in); #1;
    reset = 1'b1;

    // idle strobe: stays blank
    for (int i = 0; i < 20; i++) cyc(0, 0, 16'h0, 4'h0);
    chk_blank("idle");

    // vector table
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].s, tbl[i].l, tbl[i].d, tbl[i].p);
      chk($sformatf("tbl%0d idx", i), 32'(digit_idx), 32'(tbl[i].idx));
      chk($sformatf("tbl%0d ack", i), 32'(load_ack), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d pend", i), 32'(pending), 32'(tbl[i].pend));
      chk($sformatf("tbl%0d an", i), 32'(an_out), 32'(tbl[i].an));
      chk($sformatf("tbl%0d seg", i), 32'(seg_out), 32'(tbl[i].seg));
      chk($sformatf("tbl%0d dp", i), 32'(dp_out), 32'(tbl[i].dp));
    end

    // two loads mid-frame: last wins, one ack
    cyc(1, 0, 16'h0, 4'h0);
    cyc(0, 0, 16'h0, 4'h0);
    cyc(0, 1, 16'h1111, 4'h0);
    cyc(0, 1, 16'h2222, 4'h0);
    chk("multiload pending", 32'(pending), 32'h1);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(i % 2 == 0, 0, 16'h0, 4'h0);
      if (load_ack) acks++;
    end
    chk("multiload ack count", 32'(acks), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(i % 2 == 0, 0, 16'h0, 4'h0);
      chk("multiload seg", 32'(seg_out), 32'h24);
    end

    // load on the wrap tick itself
    cyc(0, 0, 16'h0, 4'h0);
    for (int i = 0; i < 8 && m_idx != N - 1; i++) begin
      cyc(1, 0, 16'h0, 4'h0);
      cyc(0, 0, 16'h0, 4'h0);
    end
    chk("prewrap idx", 32'(digit_idx), 32'h3);
    cyc(1, 1, 16'hFFFF, 4'h0);
    chk("wrapload ack", 32'(load_ack), 32'h1);
    chk("wrapload pending", 32'(pending), 32'h0);
    cyc(0, 0, 16'h0, 4'h0);
    chk("wrapload seg", 32'(seg_out), 32'h0E);
    chk("wrapload an", 32'(an_out), 32'hE);

    // held strobe advances once
    idx0 = digit_idx;
    for (int i = 0; i < 50; i++) cyc(1, 0, 16'h0, 4'h0);
    chk("held strobe idx", 32'(digit_idx), 32'(3'(idx0 + 3'd1)));

    // mid-frame reset with pending data
    cyc(0, 1, 16'h1234, 4'h5);
    chk("pre-reset pending", 32'(pending), 32'h1);
    #2 reset = 1'b0;
    #1 chk_blank("midreset");
    m_reset();
    @(posedge clk_in); #1;
    reset = 1'b1;
    cyc(0, 0, 16'h0, 4'h0);
    chk_blank("post-reset");

`ifdef SEG7_BLINK_EN
    blink_mask = 4'b0100;
    blink_in   = 1'b1;
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(i % 2 == 0, 0, 16'h0, 4'h0);
      chk("blink digit2 off", 32'(an_out[2]), 32'h1);
    end
    blink_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc(i % 2 == 0, 0, 16'h0, 4'h0);
      if (an_out == 4'b1011) hits++;
    end
    chk("blink restored", 32'(hits > 0), 32'h1);
`else
    hits = 0;
`endif

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
`ifdef SEG7_BLINK_EN
      blink_in   = 1'($urandom);
      blink_mask = 4'($urandom);
`endif
      cyc(1'($urandom), ($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Downstream consumer of the clock divider's slow scan output.
- Drives a multiplexed N-digit common-anode seven-segment display from a hex data word.
- Uses the divider's segment-rate square wave as a scan strobe. Rising edges are detected in the clk_in domain, so no derived clock is used.
- New display data is double-buffered. It is applied only at a frame boundary so digits never tear mid-frame.

Parameters:
- N_DIGITS, 4: number of digits scanned; 2..8.
- SEG_ACTIVE_LOW, 1: 1 drives seg_out/dp_out active-low; 0 drives them active-high.
- AN_ACTIVE_LOW, 1: 1 drives an_out active-low; 0 drives it active-high.

Ports:
- clk_in, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- scan_in, input, 1: scan strobe level (divider segment output), synchronous to clk_in.
- data_in, input, 4*N_DIGITS: hex nibbles; nibble i maps to digit i.
- dp_in, input, N_DIGITS: decimal point per digit, 1 = lit.
- load, input, 1: capture data_in/dp_in into the shadow registers.
- load_ack, output, 1: one-cycle pulse when the shadow is applied to the display.
- pending, output, 1: shadow holds data not yet displayed.
- digit_idx, output, 3: currently selected digit index.
- an_out, output, N_DIGITS: one-hot digit enable.
- seg_out, output, 7: segments; bit0 = a … bit6 = g.
- dp_out, output, 1: decimal point of the selected digit.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - digit_idx = N_DIGITS-1, scan_q = 0, running = 0.
  - active and shadow registers = 0, pending = 0, load_ack = 0.
  - an_out all inactive, seg_out all off, dp_out off (polarity per parameters).
- Tick: tick = scan_in & ~scan_q. scan_q samples scan_in every clock.
- On tick, digit_idx advances by 1. From N_DIGITS-1 it wraps to 0; this is a frame wrap.
- On the first tick after reset, running becomes 1 and digit_idx wraps to 0.
- Load handling:
  - load=1 captures data_in/dp_in into shadow and sets pending=1.
  - Repeated loads before a wrap overwrite the shadow; the last value wins. Only one ack is issued.
- Frame wrap with pending=1: active <= shadow, pending <= 0, load_ack = 1 for exactly one cycle.
- load in the same cycle as a wrap tick: the incoming data_in/dp_in go directly to active, pending stays 0, and load_ack pulses. The old shadow is discarded.
- Display outputs are registered every clock from (digit_idx, running, active):
  - They lag digit_idx by exactly 1 clock.
  - While running=0, outputs stay blank.
- Hex decode, active-high, g..a order: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - SEG_ACTIVE_LOW inverts all of these.
- scan_in held constant produces no ticks. A tick is edge-only, so a high level lasting many cycles gives one advance.
- Reset asserted mid-frame returns immediately to the reset state. Pending data is lost and no load_ack is issued.

Optional Feature:
- Macro: SEG7_BLINK_EN.
- Defined: adds ports blink_in (1 bit, typically the divider LED output) and blink_mask (N_DIGITS).
  - While blink_in=1, a digit whose blink_mask bit is set has its an_out bit forced inactive when selected.
  - Blanking is evaluated every clock with the same 1-clock output lag.
- Not defined: the ports do not exist and no blanking occurs. Behaviour is otherwise identical.

Test Plan:
1. Reset, then release. Hold scan_in=0 for 20 clocks -> an_out=4'b1111, seg_out=7'h7F, digit_idx=3, running blank.
2. Load data_in=16'h8A30, dp_in=4'b0010 before the first tick. Pulse scan_in four times:
   - load_ack pulses exactly once, at the first wrap.
   - an_out sequence 1110,1101,1011,0111.
   - seg_out sequence 40,30,08,00 (active-low).
   - dp_out=0 only on digit 1.
3. Load 16'h1111, then load 16'h2222, both mid-frame -> pending=1 until the wrap. A single load_ack; all digits then show seg_out=7'h24 ('2').
4. Assert load in the same cycle as the wrap tick with data 16'hFFFF -> load_ack that cycle+1, pending stays 0, digit 0 shows 7'h0E.
5. Hold scan_in=1 for 50 clocks -> digit_idx advances once only. Assert reset mid-frame -> all outputs blank next sample, pending=0.
6. SEG7_BLINK_EN with blink_mask=4'b0100 and blink_in=1 -> digit 2 enable never active; blink_in=0 -> digit 2 restored.
